// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Two-stage pipelined RV64 instruction encoder. Packs a format
//             code, a 64-bit immediate and register/function fields into a
//             32-bit instruction word, replacing out-of-range encodings with
//             NOP_WORD. Valid/ready streams on both sides.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready + in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//             in_funct3, in_funct7, in_imm     -- request stream
//             out_valid/out_ready + out_instr, out_range_err -- word stream
//             err_count (saturating), word_count (wrapping)
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter int          ERR_CNT_W  = 16,
  parameter int          WORD_CNT_W = 32,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [63:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic                  out_range_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam logic [2:0] C_FMT_I   = 3'b000;
  localparam logic [2:0] C_FMT_U   = 3'b001;
  localparam logic [2:0] C_FMT_S   = 3'b010;
  localparam logic [2:0] C_FMT_B   = 3'b011;
  localparam logic [2:0] C_FMT_J   = 3'b100;
  localparam logic [2:0] C_FMT_SH  = 3'b101;
  localparam logic [2:0] C_FMT_RSV = 3'b110;
  localparam logic [2:0] C_FMT_R   = 3'b111;

  // Stage 1 registers
  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_op_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [31:0] s1_imm_q;   // only the low word is ever packed
  logic        s1_err_q;

  // Stage 2 registers
  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;

  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;

  logic        w_s1_adv, w_s2_adv, w_out_hs;
  logic        w_range_err_d;
  logic [31:0] w_word_d;

  // A stage may load when it is empty or its content moves on this edge.
  assign w_s2_adv = !s2_valid_q || out_ready;
  assign w_s1_adv = !s1_valid_q || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_out_hs = s2_valid_q && out_ready;

  // Range legality: "all equal" upper bits means the value sign-extends
  // from the field width.
  always_comb begin
    w_range_err_d = 1'b0;
    case (in_fmt)
      C_FMT_I, C_FMT_S:
        w_range_err_d = !((&in_imm[63:11]) || !(|in_imm[63:11]));
      C_FMT_B:
        w_range_err_d = !((&in_imm[63:12]) || !(|in_imm[63:12])) || in_imm[0];
      C_FMT_J:
        w_range_err_d = !((&in_imm[63:20]) || !(|in_imm[63:20])) || in_imm[0];
      C_FMT_U:
        w_range_err_d = (|in_imm[11:0]) ||
                        !((&in_imm[63:31]) || !(|in_imm[63:31]));
      C_FMT_SH:
        w_range_err_d = |in_imm[63:6];
      C_FMT_RSV:
        w_range_err_d = 1'b1;
      C_FMT_R:
        w_range_err_d = 1'b0;
      default:
        w_range_err_d = 1'b1;
    endcase
  end

  // Field packing from stage-1 contents.
  always_comb begin
    w_word_d = NOP_WORD;
    case (s1_fmt_q)
      C_FMT_I:
        w_word_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      C_FMT_S:
        w_word_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[4:0], s1_op_q};
      C_FMT_B:
        w_word_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      C_FMT_U:
        w_word_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q};
      C_FMT_J:
        w_word_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                    s1_imm_q[19:12], s1_rd_q, s1_op_q};
      C_FMT_SH:
        w_word_d = {s1_f7_q[6:1], s1_imm_q[5:0], s1_rs1_q, s1_f3_q,
                    s1_rd_q, s1_op_q};
      C_FMT_R:
        w_word_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      default:
        w_word_d = NOP_WORD;
    endcase
    if (s1_err_q) begin
      w_word_d = NOP_WORD;
    end
  end

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= '0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_imm_q   <= '0;
      s1_err_q   <= 1'b0;
    end else if (w_s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_fmt_q <= in_fmt;
        s1_op_q  <= in_opcode;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm[31:0];
        s1_err_q <= w_range_err_d;
      end
    end
  end

  // Stage 2: holds its word until the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (w_s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= w_word_d;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  // Counters advance only on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else if (w_out_hs) begin
      word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
      if (s2_err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_instr     = s2_instr_q;
  assign out_range_err = s2_err_q;
  assign err_count     = err_cnt_q;
  assign word_count    = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking scoreboard bench for instr_encoder. Expected words
//             come from an independent reference encoder and are queued at
//             the input handshake, then compared at the output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

  localparam int          EW  = 2;   // small so saturation is reachable
  localparam int          WW  = 4;   // small so wrap is reachable
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [63:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_range_err;
  logic [EW-1:0] err_count;
  logic [WW-1:0] word_count;

  instr_encoder #(.ERR_CNT_W(EW), .WORD_CNT_W(WW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_range_err(out_range_err),
    .err_count(err_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_words = 0;
  int          exp_errs = 0;
  int          stall_cnt = 0;
  bit          stall_hold = 0;
  bit          last_acc = 0;
  bit          prev_held = 0;
  bit          prev_out_valid = 0;
  logic [31:0] prev_instr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder, written from numeric ranges rather than bit tests.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [63:0] imm);
    longint      s;
    longint      lim;
    logic        bad;
    logic [31:0] w;
    s   = imm;
    lim = 64'sh8000_0000;
    bad = 1'b0;
    w   = '0;
    case (f)
      3'b000: begin bad = (s < -2048) || (s > 2047); w = {imm[11:0], r1, f3, rd, op}; end
      3'b001: begin bad = (imm[11:0] != 0) || (s < -lim) || (s >= lim); w = {imm[31:12], rd, op}; end
      3'b010: begin bad = (s < -2048) || (s > 2047); w = {imm[11:5], r2, r1, f3, imm[4:0], op}; end
      3'b011: begin bad = (s < -4096) || (s > 4095) || imm[0];
                    w = {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], op}; end
      3'b100: begin bad = (s < -1048576) || (s > 1048575) || imm[0];
                    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
      3'b101: begin bad = (imm > 64'd63); w = {f7[6:1], imm[5:0], r1, f3, rd, op}; end
      3'b110: begin bad = 1'b1; end
      default: begin bad = 1'b0; w = {f7, r2, r1, f3, rd, op}; end
    endcase
    return {bad, bad ? NOP : w};
  endfunction

  // One clock: called just after a falling edge with inputs driven.
  task automatic cycle();
    exp_t        e;
    logic [32:0] r;
    out_ready = !(stall_hold || (stall_cnt > 0));
    if (stall_cnt > 0) stall_cnt--;
    #1;
    chk("in_ready", in_ready, (out_ready || (q.size() < 2)));
    chk("word_count", word_count, exp_words % (1 << WW));
    chk("err_count", err_count, exp_errs);
    if (prev_held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_instr", out_instr, prev_instr);
    end
    if (out_valid && !prev_out_valid) begin
      if (q.size() == 0) chk("spurious_valid", out_valid, 0);
      else chk("latency", cyc - q[0].stamp, 2);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_range_err", out_range_err, e.err);
        exp_words++;
        if (e.err && exp_errs < (1 << EW) - 1) exp_errs++;
      end
    end
    prev_held      = out_valid && !out_ready;
    prev_instr     = out_instr;
    prev_out_valid = out_valid;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      r = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      e.instr = r[31:0];
      e.err   = r[32];
      e.stamp = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [63:0] imm);
    in_valid = 1'b1;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", last_acc, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain_empty", q.size(), 0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_range_err", out_range_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed words from the test plan plus range boundaries
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1);              drain();
    send(3'b001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000);        drain();
    send(3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8);                drain();
    send(3'b101, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 64'd63);       drain();
    send(3'b101, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 64'd64);       drain();
    send(3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);                drain();
    send(3'b010, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd3, 7'd0, -64'sd2048);           drain();
    send(3'b010, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd3, 7'd0, 64'd2048);             drain();
    send(3'b011, 7'b1100011, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 64'd4094);             drain();
    send(3'b011, 7'b1100011, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 64'd4096);             drain();
    send(3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd1048576);        drain();
    send(3'b110, 7'b0010011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);                drain();
    send(3'b111, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 7'b0100000, 64'hDEAD_BEEF);  drain();
    send(3'b001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h8000_0000);        drain();

    // Back-to-back burst with a 3-cycle downstream stall in the middle
    for (int i = 0; i < 6; i++) begin
      send((i % 2) ? 3'b111 : 3'b000, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom), 64'($urandom_range(0, 2047)));
      if (i == 1) stall_cnt = 3;
    end
    drain();

    // More traffic so the word counter wraps
    for (int i = 0; i < 5; i++) begin
      send(3'b000, 7'b0010011, 5'(i), 5'(i + 1), 5'd0, 3'd0, 7'd0, 64'(i * 100));
    end
    drain();

    // Asynchronous reset with two words in flight
    stall_hold = 1;
    send(3'b000, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd5);
    send(3'b000, 7'b0010011, 5'd6, 5'd7, 5'd0, 3'd0, 7'd0, 64'd9);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_word_count", word_count, 0);
    chk("async_rst_err_count", err_count, 0);
    q.delete();
    exp_words = 0;
    exp_errs = 0;
    prev_held = 0;
    prev_out_valid = 0;
    stall_hold = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_idle", out_valid, 0);
    send(3'b000, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd42);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
